// File: rtl/ibex_efpga_mc_ctrl.sv
// Multi-channel eFPGA offload controller: accepts one request, waits a fixed latency or
// for the fabric done flag (with timeout), then returns the selected channel with a ready pulse.
module ibex_efpga_mc_ctrl #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned DELAY_W = 4,
    parameter int unsigned TIMEOUT = 255,
    localparam int unsigned CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_i,
    input  logic [CW-1:0]            op_i,
    input  logic                     strobe_i,
    input  logic [DELAY_W-1:0]       delay_i,
    input  logic [NUM_CH*DATA_W-1:0] result_i,
    input  logic                     efpga_done_i,
    input  logic                     abort_i,
    output logic                     ready_o,
    output logic [DATA_W-1:0]        endresult_o,
    output logic                     write_strobe_o,
    output logic                     busy_o,
    output logic                     timeout_o
);

    localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TLAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
    localparam logic [TW-1:0] TSAT = {TW{1'b1}};
    localparam logic [DELAY_W-1:0] DLY_DONE = {DELAY_W{1'b1}};

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StProc   = 2'd1;
    localparam logic [1:0] StFinish = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [DELAY_W-1:0] cnt_q, cnt_d;
    logic [TW-1:0]      tcnt_q, tcnt_d;
    logic [CW-1:0]      op_q, op_d;
    logic [DELAY_W-1:0] dly_q, dly_d;
    logic               stb_q, stb_d;
    logic               to_q, to_d;
    logic [DATA_W-1:0]  res_q, res_d;
    logic [DATA_W-1:0]  sel_result;

    // Out-of-range channel codes (non-power-of-2 NUM_CH) fall back to channel 0.
    always_comb begin
        sel_result = result_i[DATA_W-1:0];
        for (int k = 0; k < NUM_CH; k++) begin
            if (op_q == CW'(k)) begin
                sel_result = result_i[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tcnt_d  = tcnt_q;
        op_d    = op_q;
        dly_d   = dly_q;
        stb_d   = stb_q;
        to_d    = to_q;
        res_d   = res_q;

        case (state_q)
            StIdle: begin
                cnt_d  = '0;
                tcnt_d = '0;
                to_d   = 1'b0;
                if (en_i) begin
                    op_d    = op_i;
                    dly_d   = delay_i;
                    stb_d   = strobe_i;
                    state_d = StProc;
                end
            end
            StProc: begin
                if (abort_i) begin
                    state_d = StIdle;
                end else if (dly_q != DLY_DONE) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == dly_q) begin
                        res_d   = sel_result;
                        state_d = StFinish;
                    end
                end else begin
                    if (tcnt_q != TSAT) begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                    // Done beats a coincident timeout.
                    if (efpga_done_i) begin
                        res_d   = sel_result;
                        state_d = StFinish;
                    end else if ((TIMEOUT != 0) && (tcnt_q == TLAST)) begin
                        res_d   = '0;
                        to_d    = 1'b1;
                        state_d = StFinish;
                    end
                end
            end
            StFinish: begin
                to_d    = 1'b0;
                state_d = StIdle;
            end
            default: begin
                to_d    = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            tcnt_q  <= '0;
            op_q    <= '0;
            dly_q   <= '0;
            stb_q   <= 1'b0;
            to_q    <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            op_q    <= op_d;
            dly_q   <= dly_d;
            stb_q   <= stb_d;
            to_q    <= to_d;
            res_q   <= res_d;
        end
    end

    // Strobe is a decode of the latched mode, so it drops on the edge entering FINISH or IDLE.
    assign write_strobe_o = stb_q && (state_q == StProc);
    assign ready_o        = (state_q == StFinish);
    assign busy_o         = (state_q != StIdle);
    assign timeout_o      = (state_q == StFinish) && to_q;
    assign endresult_o    = res_q;

endmodule

// File: tb/tb_ibex_efpga_mc_ctrl.sv
// Directed bench for ibex_efpga_mc_ctrl: a 4-channel instance with long timeout and a
// 3-channel instance with TIMEOUT=5, sharing all stimulus except the request line.
module tb_ibex_efpga_mc_ctrl;

    logic         clk;
    logic         rst;
    logic         en_a, en_b;
    logic [1:0]   op;
    logic         strobe;
    logic [3:0]   delay;
    logic [127:0] res;
    logic         done;
    logic         abort;

    logic        ready_a, ws_a, busy_a, to_a;
    logic [31:0] endres_a;
    logic        ready_b, ws_b, busy_b, to_b;
    logic [31:0] endres_b;

    int checks = 0;
    int errors = 0;

    ibex_efpga_mc_ctrl #(
        .DATA_W (32),
        .NUM_CH (4),
        .DELAY_W(4),
        .TIMEOUT(255)
    ) dut_a (
        .clk           (clk),
        .rst           (rst),
        .en_i          (en_a),
        .op_i          (op),
        .strobe_i      (strobe),
        .delay_i       (delay),
        .result_i      (res),
        .efpga_done_i  (done),
        .abort_i       (abort),
        .ready_o       (ready_a),
        .endresult_o   (endres_a),
        .write_strobe_o(ws_a),
        .busy_o        (busy_a),
        .timeout_o     (to_a)
    );

    ibex_efpga_mc_ctrl #(
        .DATA_W (32),
        .NUM_CH (3),
        .DELAY_W(4),
        .TIMEOUT(5)
    ) dut_b (
        .clk           (clk),
        .rst           (rst),
        .en_i          (en_b),
        .op_i          (op),
        .strobe_i      (strobe),
        .delay_i       (delay),
        .result_i      (res[95:0]),
        .efpga_done_i  (done),
        .abort_i       (abort),
        .ready_o       (ready_b),
        .endresult_o   (endres_b),
        .write_strobe_o(ws_b),
        .busy_o        (busy_b),
        .timeout_o     (to_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst    = 1'b1;
        en_a   = 1'b0;
        en_b   = 1'b0;
        op     = '0;
        strobe = 1'b0;
        delay  = '0;
        res    = '0;
        done   = 1'b0;
        abort  = 1'b0;
        repeat (2) step();
        chk("rst_ready", 32'(ready_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_ws", 32'(ws_a), 32'd0);
        chk("rst_to", 32'(to_a), 32'd0);
        chk("rst_endres", endres_a, 32'd0);
        chk("rst_b_busy", 32'(busy_b), 32'd0);
        rst = 1'b0;
        step();

        // Fixed mode, delay 3, channel 2: ready in T+5.
        res[64 +: 32] = 32'hCAFEF00D;
        op     = 2'd2;
        delay  = 4'd3;
        strobe = 1'b0;
        en_a   = 1'b1;
        chk("fix_idle_busy", 32'(busy_a), 32'd0);
        step();
        en_a = 1'b0;
        chk("fix_busy", 32'(busy_a), 32'd1);
        chk("fix_ws", 32'(ws_a), 32'd0);
        chk("fix_ready_t1", 32'(ready_a), 32'd0);
        for (int i = 2; i <= 4; i++) begin
            step();
            chk("fix_ready_early", 32'(ready_a), 32'd0);
        end
        step();
        chk("fix_ready", 32'(ready_a), 32'd1);
        chk("fix_endres", endres_a, 32'hCAFEF00D);
        chk("fix_to", 32'(to_a), 32'd0);
        step();
        chk("fix_ready_once", 32'(ready_a), 32'd0);
        chk("fix_idle", 32'(busy_a), 32'd0);
        res[64 +: 32] = 32'h0;
        repeat (3) step();
        chk("fix_hold", endres_a, 32'hCAFEF00D);

        // Done-wait with strobe, done in T+8: ready in T+9.
        res[32 +: 32] = 32'h12345678;
        op     = 2'd1;
        delay  = 4'hF;
        strobe = 1'b1;
        en_a   = 1'b1;
        step();
        en_a = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            chk("dw_ws", 32'(ws_a), 32'd1);
            chk("dw_ready_early", 32'(ready_a), 32'd0);
            if (i == 8) done = 1'b1;
            step();
        end
        done = 1'b0;
        chk("dw_ready", 32'(ready_a), 32'd1);
        chk("dw_endres", endres_a, 32'h12345678);
        chk("dw_to", 32'(to_a), 32'd0);
        chk("dw_ws_low", 32'(ws_a), 32'd0);
        step();
        chk("dw_ready_once", 32'(ready_a), 32'd0);
        chk("dw_idle", 32'(busy_a), 32'd0);

        // Abort in PROC cycle 2 of a delay-8 op, then immediate new request.
        op     = 2'd0;
        delay  = 4'd8;
        strobe = 1'b1;
        en_a   = 1'b1;
        step();
        en_a = 1'b0;
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_busy", 32'(busy_a), 32'd0);
        chk("ab_ws", 32'(ws_a), 32'd0);
        chk("ab_ready", 32'(ready_a), 32'd0);
        chk("ab_endres", endres_a, 32'h12345678);
        res[96 +: 32] = 32'hA5A5A5A5;
        op     = 2'd3;
        delay  = 4'd0;
        strobe = 1'b0;
        en_a   = 1'b1;
        step();
        en_a = 1'b0;
        chk("ab_new_busy", 32'(busy_a), 32'd1);
        chk("ab_new_ready_early", 32'(ready_a), 32'd0);
        step();
        chk("ab_new_ready", 32'(ready_a), 32'd1);
        chk("ab_new_endres", endres_a, 32'hA5A5A5A5);
        step();

        // Inputs change and en re-pulses during PROC: latched op/delay win.
        res[64 +: 32] = 32'hCAFEF00D;
        res[0 +: 32]  = 32'h11111111;
        op     = 2'd2;
        delay  = 4'd2;
        en_a   = 1'b1;
        step();
        op    = 2'd0;
        delay = 4'd0;
        step();
        en_a = 1'b0;
        chk("lat_ready_t2", 32'(ready_a), 32'd0);
        step();
        chk("lat_ready_t3", 32'(ready_a), 32'd0);
        step();
        chk("lat_ready", 32'(ready_a), 32'd1);
        chk("lat_endres", endres_a, 32'hCAFEF00D);
        step();
        chk("lat_no_queue_t5", 32'(busy_a), 32'd0);
        step();
        chk("lat_no_queue_t6", 32'(busy_a), 32'd0);

        // NUM_CH=3 with op=3 selects channel 0.
        res[0 +: 32] = 32'h0BADCAFE;
        op    = 2'd3;
        delay = 4'd0;
        en_b  = 1'b1;
        step();
        en_b = 1'b0;
        chk("ch3_busy", 32'(busy_b), 32'd1);
        step();
        chk("ch3_ready", 32'(ready_b), 32'd1);
        chk("ch3_endres", endres_b, 32'h0BADCAFE);
        step();

        // Timeout after 5 PROC cycles: ready/timeout in T+6.
        res[32 +: 32] = 32'h13579BDF;
        op     = 2'd1;
        delay  = 4'hF;
        strobe = 1'b1;
        en_b   = 1'b1;
        step();
        en_b = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            chk("to_ready_early", 32'(ready_b), 32'd0);
            chk("to_ws", 32'(ws_b), 32'd1);
            step();
        end
        chk("to_ready", 32'(ready_b), 32'd1);
        chk("to_flag", 32'(to_b), 32'd1);
        chk("to_endres", endres_b, 32'd0);
        chk("to_ws_low", 32'(ws_b), 32'd0);
        step();
        chk("to_ready_once", 32'(ready_b), 32'd0);
        chk("to_flag_once", 32'(to_b), 32'd0);

        // Done in the final PROC cycle beats the timeout.
        en_b = 1'b1;
        step();
        en_b = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            chk("dt_ready_early", 32'(ready_b), 32'd0);
            if (i == 5) done = 1'b1;
            step();
        end
        done = 1'b0;
        chk("dt_ready", 32'(ready_b), 32'd1);
        chk("dt_to", 32'(to_b), 32'd0);
        chk("dt_endres", endres_b, 32'h13579BDF);
        step();

        // Asynchronous reset mid-PROC.
        op     = 2'd1;
        delay  = 4'd8;
        strobe = 1'b1;
        en_a   = 1'b1;
        step();
        en_a = 1'b0;
        step();
        chk("ar_busy_pre", 32'(busy_a), 32'd1);
        chk("ar_ws_pre", 32'(ws_a), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("ar_busy", 32'(busy_a), 32'd0);
        chk("ar_ws", 32'(ws_a), 32'd0);
        chk("ar_ready", 32'(ready_a), 32'd0);
        chk("ar_endres", endres_a, 32'd0);
        chk("ar_to", 32'(to_a), 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("ar_no_ready", 32'(ready_a), 32'd0);
        end

        // Still operational after reset.
        res[64 +: 32] = 32'hFEEDBEEF;
        op     = 2'd2;
        delay  = 4'd0;
        strobe = 1'b0;
        en_a   = 1'b1;
        step();
        en_a = 1'b0;
        step();
        chk("post_ready", 32'(ready_a), 32'd1);
        chk("post_endres", endres_a, 32'hFEEDBEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
